// File: rtl/ex_muldiv_sequencer_pkg.sv
// Shared types and helpers for the EX-stage RV32M multiply/divide sequencer.
package muldiv_types;

  localparam logic [6:0] M_FUNCT7  = 7'b0000001;
  localparam logic [5:0] LAST_ITER = 6'd31;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } muldiv_funct3_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } muldiv_state_t;

  function automatic logic is_div_op(input muldiv_funct3_t f3);
    return f3[2];
  endfunction

  function automatic logic is_signed_a(input muldiv_funct3_t f3);
    return (f3 == MUL) || (f3 == MULH) || (f3 == MULHSU) || (f3 == DIV) || (f3 == REM);
  endfunction

  function automatic logic is_signed_b(input muldiv_funct3_t f3);
    return (f3 == MUL) || (f3 == MULH) || (f3 == DIV) || (f3 == REM);
  endfunction

endpackage

// File: rtl/ex_muldiv_sequencer_if.sv
// Handshake between the EX stage and the multi-cycle multiply/divide sequencer.
interface ex_muldiv_sequencer_if;
  import muldiv_types::*;

  logic           start;
  muldiv_funct3_t funct3;
  logic [31:0]    rs1_val;
  logic [31:0]    rs2_val;
  logic           flush;
  logic           stall;
  logic           done;
  logic [31:0]    result;

  modport master (
    output start, funct3, rs1_val, rs2_val, flush,
    input  stall, done, result
  );

  modport slave (
    input  start, funct3, rs1_val, rs2_val, flush,
    output stall, done, result
  );

endinterface

// File: rtl/ex_muldiv_sequencer_iter_datapath.sv
// Shift-add multiplier / restoring divider working on operand magnitudes, one bit per step.
module muldiv_iter_datapath
  import muldiv_types::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           step,
  input  logic           fix,
  input  muldiv_funct3_t f3,
  input  logic [31:0]    op_a,
  input  logic [31:0]    op_b,
  output logic [31:0]    hi,
  output logic [31:0]    lo,
  output logic [31:0]    quot,
  output logic [31:0]    rem
);

  logic [31:0] mag_a_q, mag_a_d;
  logic [31:0] mag_b_q, mag_b_d;
  logic [63:0] acc_q, acc_d;
  logic        neg_a_q, neg_a_d;
  logic        neg_b_q, neg_b_d;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [32:0] div_diff;
  logic [63:0] prod_fixed;
  logic        neg_a_in, neg_b_in;
  logic [31:0] abs_a_in, abs_b_in;

  // acc holds {partial product, multiplier} for MUL, {partial remainder, dividend/quotient} for DIV
  always_comb begin
    neg_a_in  = is_signed_a(f3) & op_a[31];
    neg_b_in  = is_signed_b(f3) & op_b[31];
    abs_a_in  = neg_a_in ? (32'd0 - op_a) : op_a;
    abs_b_in  = neg_b_in ? (32'd0 - op_b) : op_b;
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mag_a_q} : 33'd0);
    div_shift = {acc_q[63:32], acc_q[31]};
    div_diff  = div_shift - {1'b0, mag_b_q};

    mag_a_d = mag_a_q;
    mag_b_d = mag_b_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    acc_d   = acc_q;
    if (load) begin
      mag_a_d = abs_a_in;
      mag_b_d = abs_b_in;
      neg_a_d = neg_a_in;
      neg_b_d = neg_b_in;
      acc_d   = {32'd0, is_div_op(f3) ? abs_a_in : abs_b_in};
    end else if (step) begin
      if (is_div_op(f3)) begin
        acc_d = div_diff[32] ? {div_shift[31:0], acc_q[30:0], 1'b0}
                             : {div_diff[31:0], acc_q[30:0], 1'b1};
      end else begin
        acc_d = {mul_sum, acc_q[31:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_a_q <= '0;
      mag_b_q <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      acc_q   <= '0;
    end else begin
      mag_a_q <= mag_a_d;
      mag_b_q <= mag_b_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      acc_q   <= acc_d;
    end
  end

  // Sign correction is only applied while the sequencer is in its fix-up cycle
  always_comb begin
    prod_fixed = (fix && (neg_a_q ^ neg_b_q)) ? (64'd0 - acc_q) : acc_q;
    hi         = prod_fixed[63:32];
    lo         = prod_fixed[31:0];
    quot       = (fix && (neg_a_q ^ neg_b_q)) ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
    rem        = (fix && neg_a_q) ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
  end

endmodule

// File: rtl/ex_muldiv_sequencer.sv
// EX-stage RV32M sequencer: FSM, iteration counter, divide special cases and pipeline stall.
module ex_muldiv_sequencer
  import muldiv_types::*;
#(
  parameter int XLEN = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ex_muldiv_sequencer_if.slave bus
);

  if (XLEN != 32) begin : g_xlen_check
    $error("ex_muldiv_sequencer: only XLEN=32 is supported");
  end

  muldiv_state_t  state_q, state_d;
  logic [5:0]     cnt_q, cnt_d;
  muldiv_funct3_t funct3_q, funct3_d;
  logic [31:0]    result_q, result_d;
  muldiv_funct3_t op_f3;
  logic           accept, div_zero, div_ovf, special;
  logic [31:0]    special_res;
  logic           load, step, fix;
  logic [31:0]    hi, lo, quot, rem;

  // Division special cases bypass iteration and are resolved straight from the live operands
  always_comb begin
    accept      = (state_q == IDLE) && bus.start && !bus.flush;
    div_zero    = (bus.rs2_val == 32'd0);
    div_ovf     = ((bus.funct3 == DIV) || (bus.funct3 == REM)) &&
                  (bus.rs1_val == 32'h8000_0000) && (bus.rs2_val == 32'hFFFF_FFFF);
    special     = is_div_op(bus.funct3) && (div_zero || div_ovf);
    special_res = bus.funct3[1] ? (div_zero ? bus.rs1_val : 32'd0)
                                : (div_zero ? 32'hFFFF_FFFF : 32'h8000_0000);
    op_f3       = (state_q == IDLE) ? bus.funct3 : funct3_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (accept) begin
        state_d = special ? DONE : CALC;
        cnt_d   = 6'd0;
      end
      CALC: begin
        if (bus.flush)               state_d = IDLE;
        else if (cnt_q == LAST_ITER) state_d = FIX;
        else                         cnt_d   = cnt_q + 6'd1;
      end
      FIX:     state_d = bus.flush ? IDLE : DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // stall uses the live start so the retiring instruction is released on the done cycle
  always_comb begin
    load      = accept;
    step      = (state_q == CALC) && !bus.flush;
    fix       = (state_q == FIX);
    bus.stall = bus.start && (state_q != DONE);
    bus.done  = (state_q == DONE);
  end

  always_comb begin
    funct3_d = accept ? bus.funct3 : funct3_q;
    result_d = result_q;
    if (accept && special) begin
      result_d = special_res;
    end else if (fix && !bus.flush) begin
      unique case (funct3_q)
        MUL:                 result_d = lo;
        MULH, MULHSU, MULHU: result_d = hi;
        DIV, DIVU:           result_d = quot;
        default:             result_d = rem;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      funct3_q <= MUL;
      result_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      funct3_q <= funct3_d;
      result_q <= result_d;
    end
  end

  assign bus.result = result_q;

  muldiv_iter_datapath u_datapath (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .step  (step),
    .fix   (fix),
    .f3    (op_f3),
    .op_a  (bus.rs1_val),
    .op_b  (bus.rs2_val),
    .hi    (hi),
    .lo    (lo),
    .quot  (quot),
    .rem   (rem)
  );

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Directed bench for ex_muldiv_sequencer: results, latency, stall, flush, async reset, back-to-back.
module tb_ex_muldiv_sequencer;
  import muldiv_types::*;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_done_cyc = 0;

  ex_muldiv_sequencer_if bus ();

  ex_muldiv_sequencer #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Called at posedge+1 with the sequencer idle; holds start until the done pulse (bounded)
  task automatic applyStimulus(input muldiv_funct3_t f3, input logic [31:0] a, input logic [31:0] b,
                               output int done_at, output int stalls, output logic stall_at_done,
                               output logic [31:0] res);
    int t0;
    bus.start     = 1'b1;
    bus.funct3    = f3;
    bus.rs1_val   = a;
    bus.rs2_val   = b;
    t0            = cyc;
    done_at       = -1;
    stalls        = 0;
    stall_at_done = 1'bx;
    res           = 'x;
    for (int c = 0; c < 60 && done_at < 0; c++) begin
      #2;
      if (bus.done) begin
        done_at       = cyc - t0;
        last_done_cyc = cyc;
        stall_at_done = bus.stall;
        res           = bus.result;
      end else if (bus.stall) begin
        stalls++;
      end
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
  endtask

  task automatic runOp(input string tag, input muldiv_funct3_t f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int          lat, stl;
    logic        sad;
    logic [31:0] res;
    applyStimulus(f3, a, b, lat, stl, sad, res);
    checkOutput({tag, "_result"}, res, exp_res);
    checkOutput({tag, "_latency"}, lat, exp_lat);
  endtask

  initial begin
    int          lat, stl, t0, pulses, first_done;
    logic        sad;
    logic [31:0] res;

    bus.start   = 1'b0;
    bus.funct3  = MUL;
    bus.rs1_val = '0;
    bus.rs2_val = '0;
    bus.flush   = 1'b0;
    rst_n       = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    checkOutput("reset_stall", bus.stall, 1'b0);
    checkOutput("reset_done", bus.done, 1'b0);
    checkOutput("reset_result", bus.result, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(MUL, 32'd7, 32'hFFFF_FFFD, lat, stl, sad, res);
    checkOutput("mul_result", res, 32'hFFFF_FFEB);
    checkOutput("mul_latency", lat, 34);
    checkOutput("mul_stall_cycles", stl, 34);
    checkOutput("mul_stall_at_done", sad, 1'b0);

    runOp("mulh", MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
    runOp("mulhu", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    runOp("mulhsu", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
    runOp("div_neg", DIV, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 34);
    runOp("rem_neg", REM, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 34);
    runOp("divu", DIVU, 32'd20, 32'd3, 32'd6, 34);
    runOp("remu", REMU, 32'd20, 32'd3, 32'd2, 34);
    runOp("div_by_zero", DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    runOp("rem_by_zero", REM, 32'd5, 32'd0, 32'd5, 1);
    runOp("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    runOp("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

    // Squash a divide on its 10th cycle, then issue a multiply on the following cycle
    bus.start   = 1'b1;
    bus.funct3  = DIV;
    bus.rs1_val = 32'd100;
    bus.rs2_val = 32'd7;
    t0          = cyc;
    pulses      = 0;
    repeat (10) begin
      #2;
      if (bus.done) pulses++;
      @(posedge clk);
      #1;
    end
    bus.flush = 1'b1;
    #2;
    if (bus.done) pulses++;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    checkOutput("flush_no_done", pulses, 0);
    checkOutput("flush_result_held", bus.result, 32'd0);
    applyStimulus(MUL, 32'd9, 32'd11, lat, stl, sad, res);
    checkOutput("flush_mul_result", res, 32'd99);
    checkOutput("flush_mul_done_cycle", last_done_cyc - t0, 45);

    // Async reset in the middle of a multiply
    bus.start   = 1'b1;
    bus.funct3  = MUL;
    bus.rs1_val = 32'd5;
    bus.rs2_val = 32'd6;
    repeat (5) @(posedge clk);
    #1;
    bus.start = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_stall", bus.stall, 1'b0);
    checkOutput("async_reset_done", bus.done, 1'b0);
    checkOutput("async_reset_result", bus.result, 32'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    runOp("b2b_first", MUL, 32'd3, 32'd5, 32'd15, 34);
    first_done = last_done_cyc;
    runOp("b2b_second", MUL, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 34);
    checkOutput("b2b_done_gap", last_done_cyc - first_done, 35);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
